alu_arbiter: RTL and testbench

//  Shares one rv32i ALU instance between two requesters, e.g. the execute stage
//  (port 0) and the address/branch-compare unit (port 1).
//  - Accepts at most one operation per cycle through a valid/ready handshake.
//  - Arbitrates contention round-robin.
//  - Registers the ALU result into a single output slot that honours backpressure.
//  - Tags each result with the requester index.

---
 rtl/alu_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_alu_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter in front of a single rv32i ALU with a one-entry result slot.
// Optional feature macro: ALU_ARB_FIXED_PRIO_EN (requester 0 always wins contention).
module alu_arbiter #(
    parameter int          XLEN        = 32,
    parameter int unsigned RESET_GRANT = 0
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [XLEN-1:0] req0_a,
    input  logic [XLEN-1:0] req0_b,
    input  logic [2:0]      req0_funct3,
    input  logic [6:0]      req0_funct7,
    input  logic [6:0]      req0_opcode,

    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [XLEN-1:0] req1_a,
    input  logic [XLEN-1:0] req1_b,
    input  logic [2:0]      req1_funct3,
    input  logic [6:0]      req1_funct7,
    input  logic [6:0]      req1_opcode,

    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_result,
    output logic            rsp_id
);

    localparam logic [6:0] OP_REG = 7'b0110011;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } slot_state_e;

    // SUB only for register-register ops; SRA/SRAI both select on funct7[5].
    function automatic logic [31:0] alu_op(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [2:0]  f3,
        input logic        alt,
        input logic [6:0]  op
    );
        logic [4:0] shamt;
        shamt = b[4:0];
        case (f3)
            3'b000:  alu_op = (alt && (op == OP_REG)) ? (a - b) : (a + b);
            3'b001:  alu_op = a << shamt;
            3'b010:  alu_op = {31'd0, ($signed(a) < $signed(b))};
            3'b011:  alu_op = {31'd0, (a < b)};
            3'b100:  alu_op = a ^ b;
            3'b101:  alu_op = alt ? 32'($signed(a) >>> shamt) : (a >> shamt);
            3'b110:  alu_op = a | b;
            3'b111:  alu_op = a & b;
            default: alu_op = 32'd0;
        endcase
    endfunction

    slot_state_e     state_q;
    logic [XLEN-1:0] result_q;
    logic            id_q;

    logic            grant0;
    logic            grant1;
    logic            can_accept;
    logic            accept;
    logic [XLEN-1:0] sel_a;
    logic [XLEN-1:0] sel_b;
    logic [2:0]      sel_f3;
    logic            sel_alt;
    logic [6:0]      sel_op;
    logic [XLEN-1:0] alu_res;

`ifndef ALU_ARB_FIXED_PRIO_EN
    logic            prio_q;
`endif

    // Grant selection: a lone requester always wins, contention resolved by priority.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
        grant0 = req0_valid;
        grant1 = req1_valid & ~req0_valid;
`else
        if (req0_valid && req1_valid) begin
            grant0 = ~prio_q;
            grant1 = prio_q;
        end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
        end
`endif
    end

    assign can_accept = (state_q == ST_EMPTY) | rsp_ready;
    assign req0_ready = can_accept & grant0;
    assign req1_ready = can_accept & grant1;
    assign accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);

    // Operand mux toward the shared ALU.
    always_comb begin
        sel_a   = req0_a;
        sel_b   = req0_b;
        sel_f3  = req0_funct3;
        sel_alt = req0_funct7[5];
        sel_op  = req0_opcode;
        if (grant1) begin
            sel_a   = req1_a;
            sel_b   = req1_b;
            sel_f3  = req1_funct3;
            sel_alt = req1_funct7[5];
            sel_op  = req1_opcode;
        end else begin
            sel_a   = req0_a;
            sel_b   = req0_b;
            sel_f3  = req0_funct3;
            sel_alt = req0_funct7[5];
            sel_op  = req0_opcode;
        end
        alu_res = alu_op(sel_a, sel_b, sel_f3, sel_alt, sel_op);
    end

    // Only funct7[5] carries meaning for the rv32i base ALU.
    logic unused_funct7;
    assign unused_funct7 = ^{req0_funct7[6], req0_funct7[4:0],
                             req1_funct7[6], req1_funct7[4:0]};

    // Output slot FSM; a drain and a new accept in the same cycle keep it FULL.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_EMPTY;
            result_q <= '0;
            id_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_q  <= ST_FULL;
                        result_q <= alu_res;
                        id_q     <= grant1;
                    end else begin
                        state_q  <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (accept) begin
                        state_q  <= ST_FULL;
                        result_q <= alu_res;
                        id_q     <= grant1;
                    end else if (rsp_ready) begin
                        state_q  <= ST_EMPTY;
                    end else begin
                        state_q  <= ST_FULL;
                    end
                end
                default: begin
                    state_q <= ST_EMPTY;
                end
            endcase
        end
    end

`ifndef ALU_ARB_FIXED_PRIO_EN
    // Priority flips away from whoever was just served, contended or not.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q <= 1'(RESET_GRANT);
        end else if (accept) begin
            prio_q <= ~grant1;
        end else begin
            prio_q <= prio_q;
        end
    end
`endif

    assign rsp_valid  = (state_q == ST_FULL);
    assign rsp_result = result_q;
    assign rsp_id     = id_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed-vector bench for alu_arbiter; honours ALU_ARB_FIXED_PRIO_EN when defined.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_funct3, req1_funct3;
    logic [6:0]  req0_funct7, req0_opcode, req1_funct7, req1_opcode;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_result;

    int n_vec = 0;
    int n_err = 0;

    alu_arbiter #(.XLEN(32), .RESET_GRANT(0)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_funct3(req0_funct3), .req0_funct7(req0_funct7), .req0_opcode(req0_opcode),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_funct3(req1_funct3), .req1_funct7(req1_funct7), .req1_opcode(req1_opcode),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_id(rsp_id)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Single-requester op on port 0, result checked one edge later.
    task automatic apply_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [2:0] f3, input logic [6:0] f7, input logic [6:0] op,
                            input logic [31:0] exp);
        @(negedge clk);
        req1_valid = 1'b0;
        req0_valid = 1'b1;
        req0_a = a; req0_b = b; req0_funct3 = f3; req0_funct7 = f7; req0_opcode = op;
        @(posedge clk); #1;
        check_eq(tag, rsp_result, exp);
    endtask

    task automatic load_contended();
        req0_a = 32'd10; req0_b = 32'd3; req0_funct3 = 3'b000;
        req0_funct7 = 7'h20; req0_opcode = 7'b0110011;
        req1_a = 32'h8000_0000; req1_b = 32'd4; req1_funct3 = 3'b101;
        req1_funct7 = 7'h20; req1_opcode = 7'b0010011;
        req0_valid = 1'b1; req1_valid = 1'b1;
    endtask

    logic        exp_id;
    logic [31:0] exp_res;

    initial begin
        rst = 1'b1; rsp_ready = 1'b1;
        req0_valid = 1'b0; req0_a = 32'd0; req0_b = 32'd0;
        req0_funct3 = 3'd0; req0_funct7 = 7'd0; req0_opcode = 7'd0;
        req1_valid = 1'b0; req1_a = 32'd0; req1_b = 32'd0;
        req1_funct3 = 3'd0; req1_funct7 = 7'd0; req1_opcode = 7'd0;

        // Reset values before any clock edge
        #1;
        check_eq("rst_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_result", rsp_result, 32'd0);
        check_eq("rst_id", 32'(rsp_id), 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        check_eq("idle_rdy0", 32'(req0_ready), 32'd0);
        check_eq("idle_rdy1", 32'(req1_ready), 32'd0);

        // Lone requester 1
        req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd2;
        req1_funct3 = 3'b000; req1_funct7 = 7'h00; req1_opcode = 7'b0110011;
        #1;
        check_eq("lone_rdy1", 32'(req1_ready), 32'd1);
        check_eq("lone_rdy0", 32'(req0_ready), 32'd0);
        @(posedge clk); #1;
        check_eq("lone_valid", 32'(rsp_valid), 32'd1);
        check_eq("lone_result", rsp_result, 32'd3);
        check_eq("lone_id", 32'(rsp_id), 32'd1);

        // Single ADD on port 0
        @(negedge clk);
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd7;
        req0_funct3 = 3'b000; req0_funct7 = 7'h00; req0_opcode = 7'b0110011;
        @(posedge clk); #1;
        check_eq("add_valid", 32'(rsp_valid), 32'd1);
        check_eq("add_result", rsp_result, 32'd12);
        check_eq("add_id", 32'(rsp_id), 32'd0);

        // Contention from a fresh reset: priority starts at requester 0
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        load_contended();
        for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            exp_id = 1'b0;
`else
            exp_id = 1'(i % 2);
`endif
            exp_res = exp_id ? 32'hF800_0000 : 32'd7;
            #1;
            check_eq($sformatf("rr_rdy1_%0d", i), 32'(req1_ready), 32'(exp_id));
            @(posedge clk); #1;
            check_eq($sformatf("rr_result_%0d", i), rsp_result, exp_res);
            check_eq($sformatf("rr_id_%0d", i), 32'(rsp_id), 32'(exp_id));
            @(negedge clk);
        end

        // Backpressure: slot holds last result, no requester is accepted
        exp_res = rsp_result;
        exp_id  = rsp_id;
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq($sformatf("bp_rdy0_%0d", i), 32'(req0_ready), 32'd0);
            check_eq($sformatf("bp_rdy1_%0d", i), 32'(req1_ready), 32'd0);
            @(posedge clk); #1;
            check_eq($sformatf("bp_hold_%0d", i), rsp_result, exp_res);
            check_eq($sformatf("bp_valid_%0d", i), 32'(rsp_valid), 32'd1);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        // Last contended grant went to the other side (or always 0 under fixed priority)
`ifdef ALU_ARB_FIXED_PRIO_EN
        exp_id = 1'b0;
`else
        exp_id = ~exp_id;
`endif
        #1;
        check_eq("bp_release_rdy", 32'(exp_id ? req1_ready : req0_ready), 32'd1);
        @(posedge clk); #1;
        check_eq("bp_next_valid", 32'(rsp_valid), 32'd1);
        check_eq("bp_next_id", 32'(rsp_id), 32'(exp_id));
        check_eq("bp_next_result", rsp_result, exp_id ? 32'hF800_0000 : 32'd7);

        // Asynchronous reset mid-stream; first contended grant goes back to requester 0
        @(negedge clk); #2;
        check_eq("pre_rst_valid", 32'(rsp_valid), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("async_valid", 32'(rsp_valid), 32'd0);
        check_eq("async_result", rsp_result, 32'd0);
        @(negedge clk); rst = 1'b0;
        #1;
        check_eq("post_rst_rdy0", 32'(req0_ready), 32'd1);
        check_eq("post_rst_rdy1", 32'(req1_ready), 32'd0);
        @(posedge clk); #1;
        check_eq("post_rst_id", 32'(rsp_id), 32'd0);
        check_eq("post_rst_result", rsp_result, 32'd7);

        // ALU corner vectors, back-to-back on port 0
        apply_op("sltu_max",  32'd1, 32'hFFFF_FFFF, 3'b011, 7'h00, 7'b0110011, 32'd1);
        apply_op("slt_neg1",  32'd1, 32'hFFFF_FFFF, 3'b010, 7'h00, 7'b0110011, 32'd0);
        apply_op("sll_b33",   32'd3, 32'd33,        3'b001, 7'h00, 7'b0110011, 32'd6);
        apply_op("xor",       32'hF0F0_00FF, 32'h0FF0_0F0F, 3'b100, 7'h00, 7'b0110011, 32'hFF00_0FF0);
        apply_op("or",        32'h00FF_0000, 32'h0000_00F0, 3'b110, 7'h00, 7'b0110011, 32'h00FF_00F0);
        apply_op("and",       32'hFFFF_0000, 32'h0F0F_0F0F, 3'b111, 7'h00, 7'b0110011, 32'h0F0F_0000);
        apply_op("srl",       32'h8000_0000, 32'd4,  3'b101, 7'h00, 7'b0110011, 32'h0800_0000);
        apply_op("sra_b36",   32'h8000_0000, 32'd36, 3'b101, 7'h20, 7'b0110011, 32'hF800_0000);
        apply_op("addi_f7",   32'd10, 32'd3, 3'b000, 7'h20, 7'b0010011, 32'd13);
        apply_op("sub_neg",   32'd3, 32'd10, 3'b000, 7'h20, 7'b0110011, 32'hFFFF_FFF9);
        apply_op("slt_lt",    32'hFFFF_FFFB, 32'd3, 3'b010, 7'h00, 7'b0110011, 32'd1);
        check_eq("vec_id", 32'(rsp_id), 32'd0);

        // Drain with nothing pending: slot returns to empty
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk); #1;
        check_eq("drain_valid", 32'(rsp_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
